// File: rtl/link_pkg.sv
// Shared definitions for the slave-to-master one-wire sample link (receiver and transmitter).
package link_pkg;

    localparam int FRAME_BITS = 22;
    localparam int DATA_W     = 18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_PARITY,
        ST_STOP,
        ST_RECOVER
    } state_e;

    typedef struct packed {
        logic              ch;
        logic [DATA_W-1:0] data;
    } sample_t;

    // Even parity over {ch, data, p}: returns 1 when the frame's parity bit is wrong.
    function automatic logic parity_bad(sample_t s, logic p);
        return ^{s, p};
    endfunction

endpackage

// File: rtl/link_rx_fifo.sv
// Synchronous first-word-fall-through FIFO of link samples.
module link_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  link_pkg::sample_t push_data,
    input  logic              pop,
    output link_pkg::sample_t pop_data,
    output logic              full,
    output logic              empty
);
    import link_pkg::*;

    localparam int AW = $clog2(DEPTH);

    sample_t       mem_q [DEPTH];
    sample_t       mem_d [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/slave_link_rx.sv
// Master-side receiver for one slave serial link: deserialises, checks and buffers
// {ch, data} frames and presents them as a valid/ready sample stream.
module slave_link_rx #(
    parameter int BIT_CYCLES = 4,
    parameter int DATA_W     = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              clear_errors,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_ch,
    output logic              parity_error,
    output logic              framing_error,
    output logic              overflow,
    output logic [7:0]        drop_count
);
    import link_pkg::*;

    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BIT_CYCLES - 1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [1:0]        settle_q, settle_d;
    logic              prev_high_q, prev_high_d;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W:0]   shift_q, shift_d;
    logic              par_q, par_d;
    logic              push_q, push_d;
    logic              parity_error_q, parity_error_d;
    logic              framing_error_q, framing_error_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_count_q, drop_count_d;

    logic              line;
    logic              expire;
    logic              perr_set;
    logic              ferr_set;
    logic              ovf_set;
    logic [7:0]        drop_base;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    sample_t           fifo_head;

    assign line   = sync2_q;
    assign expire = (cnt_q == '0);

    // The sync flops reset high and are not trusted until two real samples have passed;
    // a start needs a genuine high-to-low edge, so a reset mid-frame waits for the line to go idle.
    always_comb begin
        sync1_d     = serial_in;
        sync2_d     = sync1_q;
        settle_d    = {settle_q[0], 1'b1};
        prev_high_d = settle_q[1] & line;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        push_d   = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (prev_high_q && !line) begin
                    state_d = ST_START;
                    cnt_d   = CNT_HALF;
                end
            end
            ST_START: begin
                if (!expire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!line) begin
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_FULL;
                    bit_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!expire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d = {shift_q[DATA_W-1:0], line};
                    cnt_d   = CNT_FULL;
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(DATA_W)) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (!expire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    par_d   = line;
                    cnt_d   = CNT_FULL;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (!expire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!line) begin
                    ferr_set = 1'b1;
                    cnt_d    = CNT_FULL;
                    state_d  = ST_RECOVER;
                end else if (parity_bad(sample_t'(shift_q), par_q)) begin
                    perr_set = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    push_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RECOVER: begin
                if (!line) begin
                    cnt_d = CNT_FULL;
                end else if (expire) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop     = ~fifo_empty & sample_ready;
    assign ovf_set = push_q & fifo_full & ~pop;

    // Sticky flags: a set in the same cycle as clear_errors wins.
    always_comb begin
        parity_error_d  = perr_set | (parity_error_q & ~clear_errors);
        framing_error_d = ferr_set | (framing_error_q & ~clear_errors);
        overflow_d      = ovf_set | (overflow_q & ~clear_errors);
        drop_base       = clear_errors ? '0 : drop_count_q;
        drop_count_d    = drop_base;
        if (ovf_set && drop_base != 8'hFF) begin
            drop_count_d = drop_base + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            settle_q        <= '0;
            prev_high_q     <= 1'b0;
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            bit_q           <= '0;
            shift_q         <= '0;
            par_q           <= 1'b0;
            push_q          <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
            overflow_q      <= 1'b0;
            drop_count_q    <= '0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            settle_q        <= settle_d;
            prev_high_q     <= prev_high_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_q           <= bit_d;
            shift_q         <= shift_d;
            par_q           <= par_d;
            push_q          <= push_d;
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
            overflow_q      <= overflow_d;
            drop_count_q    <= drop_count_d;
        end
    end

    link_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (sample_t'(shift_q)),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign sample_valid  = ~fifo_empty;
    assign sample_data   = fifo_head.data;
    assign sample_ch     = fifo_head.ch;
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;
    assign overflow      = overflow_q;
    assign drop_count    = drop_count_q;

endmodule

// File: doc/slave_link_rx.md
Name: slave_link_rx

Overview:
Receives the one-wire serial sample stream (serial_data1/3/4) that each slave FPGA sends to the master FPGA. Each frame carries one 18-bit AD7673 conversion result and a channel tag. The block deserialises and checks each frame, buffers accepted samples, and presents them as a valid/ready stream to the master's packetiser and USB FIFO path. The master instantiates one slave_link_rx per slave link; all instances run on clk, the same clock forwarded to the slaves as clk_wire.

Parameters:
BIT_CYCLES, 4, clk cycles per serial bit; even, >= 4
DATA_W, 18, sample width (AD7673 resolution)
FIFO_DEPTH, 4, output buffer entries; power of 2

Ports:
clk  in  1  system clock; the same clock the slaves use to drive serial_data
reset  in  1  synchronous, active-high reset
serial_in  in  1  serial line from slave; idles high
clear_errors  in  1  one-cycle pulse; clears the sticky flags and drop_count
sample_valid  out  1  head of FIFO valid
sample_ready  in  1  consumer accepts head when sample_valid & sample_ready
sample_data  out  DATA_W  sample value, MSB-first as received
sample_ch  out  1  0 = first ADC of slave (Y1/X1/X3), 1 = second ADC
parity_error  out  1  sticky; a frame failed even parity
framing_error  out  1  sticky; stop bit sampled low
overflow  out  1  sticky; a good frame was dropped because FIFO full
drop_count  out  8  good frames dropped on overflow; saturates at 255

Behaviour:
- Frame format, 22 bits, each BIT_CYCLES long:
  - start bit 0
  - ch
  - data[17:0], MSB first
  - parity p, where ch^data^p has even parity (total count of ones is even)
  - stop bit 1
- serial_in passes through a 2-FF synchroniser before any use. It is treated as asynchronous-safe even though it is nominally clk-aligned.
- Bit counter and cycle counter are sized to fit 21 and BIT_CYCLES-1.
- FSM states: IDLE, START, SHIFT, PARITY, STOP, RECOVER.
  - IDLE: a 1->0 transition of the synced line enters START and loads cycle counter = BIT_CYCLES/2-1.
  - START: at count expiry (mid-bit), line 0 -> SHIFT with counter = BIT_CYCLES-1. Line 1 -> IDLE; this is a glitch, no error flagged.
  - SHIFT: sample at each expiry; 19 samples (ch, then data MSB..LSB) shifted into a 19-bit register, then -> PARITY.
  - PARITY: one sample, then -> STOP.
  - STOP, line sampled 1 and parity good: push {ch, data} into FIFO, or drop if full; -> IDLE.
  - STOP, line sampled 1 and parity bad: discard the frame, set parity_error; -> IDLE.
  - STOP, line sampled 0: discard the frame, set framing_error (regardless of parity); -> RECOVER.
  - RECOVER: wait until the synced line is 1 for one full BIT_CYCLES, then -> IDLE.
- Push happens in the cycle after the stop-bit sample. sample_valid rises the following cycle when the FIFO was empty.
  - Latency from stop-bit mid-sample to sample_valid = 2 clk.
- FIFO is first-word-fall-through.
  - A simultaneous push and pop when full is allowed: the pop frees the slot, so the push is accepted and no overflow is flagged.
  - A push when full and no pop drops the frame, sets overflow and increments drop_count (saturating).
- sample_data and sample_ch hold stable while sample_valid=1 and sample_ready=0.
- clear_errors on the same cycle as a new error event: the set wins, so the flag ends 1.
- Reset values:
  - FSM = IDLE; FIFO empty; sample_valid = 0.
  - sample_data = 0; sample_ch = 0.
  - all sticky flags = 0; drop_count = 0.
  - synchroniser flops = 1, so the line is seen as idle and reset release produces no false start.
- Reset mid-frame aborts the frame with no push and no error. The next start is only detected after the line returns high.
- Back-to-back frames (stop bit immediately followed by start) are received without loss.

Decomposition:
- Shared package link_pkg:
  - FRAME_BITS=22, DATA_W=18
  - state enum
  - typedef sample_t = {ch, data[17:0]}
- The slave-side transmitter uses the same package.
- Sub-module link_rx_fifo: a synchronous FWFT FIFO of sample_t with push, pop, full and empty. It is reusable by the master's USB packetiser.

Test Plan:
- Single frame, ch=1, data=0x2A5A5, p=0, BIT_CYCLES=4 -> sample_valid 2 clk after the stop mid-sample; sample_data=0x2A5A5, sample_ch=1; no flags.
- Same frame with p=1 -> no sample_valid; parity_error=1. clear_errors pulse -> parity_error=0.
- Frame with stop bit=0, then the line is held high for 4 clk -> framing_error=1, no push. A following good frame, ch=0, data=0x00001, p=1, is received correctly.
- sample_ready=0, 6 good back-to-back frames with data 1..6 -> FIFO holds 1..4; overflow=1; drop_count=2. Then assert sample_ready -> 1,2,3,4 emerge in order.
- 1-cycle low glitch on the idle line -> START aborts; no valid, no flags.
- Reset asserted mid-SHIFT, remainder of the frame still driven -> no valid, no flags. The next full frame is received correctly.
